// File: rtl/alarm_pkg.sv
// alarm_pkg: shared keypad-alarm constants, CLOCK_50 timing and entry FSM encoding.
package alarm_pkg;
  localparam int CODE_DIGITS = 4;
  localparam int DIGIT_W = 4;
  localparam int CLOCK_HZ = 50_000_000;
  localparam int DEF_PENALTY_CYCLES = CLOCK_HZ;
  localparam int DEF_TIMEOUT_CYCLES = 10 * CLOCK_HZ;
  typedef enum logic [2:0] {
    S_IDLE,
    S_ENTRY,
    S_CMP,
    S_WAIT,
    S_PENALTY,
    S_ALARM
  } state_t;
endpackage

// File: rtl/cycle_timer.sv
// cycle_timer: loadable saturating down-counter; done is high while the count is zero.
module cycle_timer #(
  parameter int CNT_W = 29
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);
  logic [CNT_W-1:0] count;
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) count <= '0;
    else if (load) count <= load_val;
    else if (count != '0) count <= count - 1'b1;
  assign done = (count == '0);
endmodule

// File: rtl/passcode_entry_ctrl.sv
// passcode_entry_ctrl: collects keypad digits into the attempt register, runs the validator
// handshake, and enforces failure penalty, inactivity timeout and the sticky alarm request.
module passcode_entry_ctrl import alarm_pkg::*; #(
  parameter int NUM_DIGITS = CODE_DIGITS,
  parameter int MAX_FAILS = 3,
  parameter int PENALTY_CYCLES = DEF_PENALTY_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int CNT_W = 29
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               enable,
  input  logic               digit_valid,
  input  logic [DIGIT_W-1:0] digit,
  input  logic               enter,
  input  logic               cmp_done,
  input  logic               cmp_match,
  output logic               attempt_clr,
  output logic               attempt_we,
  output logic [DIGIT_W-1:0] digit_out,
  output logic               cmp_req,
  output logic               pass_ok,
  output logic               pass_fail,
  output logic               alarm_req,
  output logic [2:0]         digits_entered,
  output logic [1:0]         fails,
  output logic               busy
);
  localparam logic [2:0] FULL = 3'(NUM_DIGITS);
  localparam logic [1:0] FAIL_MAX = 2'(MAX_FAILS);
  state_t state;
  logic acc_digit, fail_now, tmr_load, tmr_done;
  logic [1:0] fails_nx;
  logic [CNT_W-1:0] tmr_val;
  assign acc_digit = enable && digit_valid &&
                     (state == S_IDLE || (state == S_ENTRY && digits_entered < FULL));
  // a premature enter shares the mismatch path; a same-cycle digit suppresses enter
  assign fail_now = (state == S_ENTRY && enable && !digit_valid && enter && digits_entered != FULL) ||
                    (state == S_WAIT && cmp_done && !cmp_match);
  assign fails_nx = (fails == FAIL_MAX) ? fails : fails + 2'd1;
  assign tmr_load = acc_digit || fail_now;
  assign tmr_val = fail_now ? CNT_W'(PENALTY_CYCLES - 1) : CNT_W'(TIMEOUT_CYCLES - 1);
  cycle_timer #(.CNT_W(CNT_W)) u_timer (
    .clock(clock),
    .resetn(resetn),
    .load(tmr_load),
    .load_val(tmr_val),
    .done(tmr_done)
  );
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      state <= S_IDLE;
      attempt_clr <= 1'b0;
      attempt_we <= 1'b0;
      digit_out <= '0;
      cmp_req <= 1'b0;
      pass_ok <= 1'b0;
      pass_fail <= 1'b0;
      alarm_req <= 1'b0;
      digits_entered <= '0;
      fails <= '0;
      busy <= 1'b0;
    end else begin
      attempt_clr <= 1'b0;
      attempt_we <= 1'b0;
      cmp_req <= 1'b0;
      pass_ok <= 1'b0;
      pass_fail <= 1'b0;
      busy <= 1'b0;
      if (acc_digit) begin
        attempt_we <= 1'b1;
        digit_out <= digit;
      end
      case (state)
        S_IDLE: if (acc_digit) begin
          state <= S_ENTRY;
          attempt_clr <= 1'b1;
          digits_entered <= 3'd1;
        end
        S_ENTRY:
          if (!enable) begin
            attempt_clr <= 1'b1;
            digits_entered <= '0;
            state <= S_IDLE;
          end else if (acc_digit) digits_entered <= digits_entered + 3'd1;
          else if (enter && !digit_valid) begin
            if (digits_entered == FULL) begin
              state <= S_CMP;
              cmp_req <= 1'b1;
              busy <= 1'b1;
            end
          end else if (tmr_done) begin
            attempt_clr <= 1'b1;
            digits_entered <= '0;
            state <= S_IDLE;
          end
        S_CMP: begin
          state <= S_WAIT;
          busy <= 1'b1;
        end
        S_WAIT:
          if (!cmp_done) busy <= 1'b1;
          else if (cmp_match) begin
            pass_ok <= 1'b1;
            fails <= '0;
            attempt_clr <= 1'b1;
            digits_entered <= '0;
            state <= S_IDLE;
          end
        S_PENALTY:
          if (!enable) begin
            attempt_clr <= 1'b1;
            state <= S_IDLE;
          end else if (tmr_done) state <= S_IDLE;
          else busy <= 1'b1;
        S_ALARM: state <= S_ALARM;
        default: state <= S_IDLE;
      endcase
      if (fail_now) begin
        pass_fail <= 1'b1;
        fails <= fails_nx;
        attempt_clr <= 1'b1;
        digits_entered <= '0;
        state <= (fails_nx == FAIL_MAX) ? S_ALARM : S_PENALTY;
        busy <= (fails_nx != FAIL_MAX);
        alarm_req <= alarm_req || (fails_nx == FAIL_MAX);
      end
    end
endmodule

// File: tb/tb_passcode_entry_ctrl.sv
// tb_passcode_entry_ctrl: directed sequence with a digit scoreboard for passcode_entry_ctrl.
module tb_passcode_entry_ctrl;
  logic clock = 0, resetn = 0, enable = 0, digit_valid = 0, enter = 0, cmp_done = 0, cmp_match = 0;
  logic [3:0] digit = 0;
  logic attempt_clr, attempt_we, cmp_req, pass_ok, pass_fail, alarm_req, busy;
  logic [3:0] digit_out;
  logic [2:0] digits_entered;
  logic [1:0] fails;
  logic [15:0] outs;
  int n_cmp = 0, n_err = 0, cnt_req = 0, cnt_fail = 0;
  logic [3:0] exp_q[$];

  always #10 clock = ~clock;

  passcode_entry_ctrl #(.PENALTY_CYCLES(8), .TIMEOUT_CYCLES(16)) dut (
    .clock(clock), .resetn(resetn), .enable(enable), .digit_valid(digit_valid), .digit(digit),
    .enter(enter), .cmp_done(cmp_done), .cmp_match(cmp_match), .attempt_clr(attempt_clr),
    .attempt_we(attempt_we), .digit_out(digit_out), .cmp_req(cmp_req), .pass_ok(pass_ok),
    .pass_fail(pass_fail), .alarm_req(alarm_req), .digits_entered(digits_entered),
    .fails(fails), .busy(busy)
  );

  assign outs = {attempt_clr, attempt_we, digit_out, cmp_req, pass_ok, pass_fail, alarm_req,
                 digits_entered, fails, busy};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // every attempt_we must match the oldest digit the bench expects to be written
  always @(negedge clock) begin
    logic [31:0] e;
    if (cmp_req) cnt_req++;
    if (pass_fail) cnt_fail++;
    if (attempt_we) begin
      e = 'x;
      if (exp_q.size() > 0) e = {28'd0, exp_q.pop_front()};
      check("we_digit", {28'd0, digit_out}, e);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic press(input logic [3:0] d, input bit acc);
    digit_valid = 1;
    digit = d;
    if (acc) exp_q.push_back(d);
    tick();
    digit_valid = 0;
  endtask

  task automatic enter_key();
    enter = 1;
    tick();
    enter = 0;
  endtask

  task automatic respond(input logic m);
    tick();
    cmp_done = 1;
    cmp_match = m;
    tick();
    cmp_done = 0;
    cmp_match = 0;
  endtask

  task automatic attempt4(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] d);
    press(a, 1);
    press(b, 1);
    press(c, 1);
    press(d, 1);
    enter_key();
  endtask

  task automatic wait_penalty();
    for (int i = 1; i <= 8; i++) begin
      tick();
      check("penalty_busy", busy, i < 8);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) tick();
    check("reset_outs", outs, 0);
    resetn = 1;
    enable = 1;
    tick();
    // correct code 2211
    press(2, 1);
    check("first_clr", attempt_clr, 1);
    check("first_we", attempt_we, 1);
    check("first_de", digits_entered, 1);
    press(2, 1);
    press(1, 1);
    press(1, 1);
    check("full_de", digits_entered, 4);
    enter_key();
    check("t1_req", cmp_req, 1);
    check("t1_busy", busy, 1);
    repeat (2) tick();
    cmp_done = 1;
    cmp_match = 1;
    tick();
    cmp_done = 0;
    cmp_match = 0;
    check("t1_ok", pass_ok, 1);
    check("t1_fails", fails, 0);
    check("t1_clr", attempt_clr, 1);
    check("t1_idle_busy", busy, 0);
    tick();
    check("t1_ok_pulse", pass_ok, 0);
    check("t1_nreq", cnt_req, 1);
    check("t1_q", exp_q.size(), 0);
    // premature enter after three digits
    press(1, 1);
    press(2, 1);
    press(3, 1);
    enter_key();
    check("t2_fail", pass_fail, 1);
    check("t2_fails", fails, 1);
    check("t2_busy", busy, 1);
    check("t2_req", cmp_req, 0);
    check("t2_de", digits_entered, 0);
    digit_valid = 1;
    digit = 9;
    wait_penalty();
    digit_valid = 0;
    tick();
    check("t2_drop_de", digits_entered, 0);
    check("t2_nreq", cnt_req, 1);
    // inactivity timeout
    press(5, 1);
    press(6, 1);
    repeat (15) tick();
    check("t3_pre_de", digits_entered, 2);
    check("t3_pre_clr", attempt_clr, 0);
    tick();
    check("t3_clr", attempt_clr, 1);
    check("t3_de", digits_entered, 0);
    check("t3_fails", fails, 1);
    check("t3_busy", busy, 0);
    // fifth digit ignored
    press(1, 1);
    press(2, 1);
    press(3, 1);
    press(4, 1);
    press(5, 0);
    check("t4_de", digits_entered, 4);
    enter_key();
    check("t4_req", cmp_req, 1);
    respond(1);
    check("t4_ok", pass_ok, 1);
    check("t4_fails", fails, 0);
    // digit and enter together on the fourth digit
    press(7, 1);
    press(8, 1);
    press(9, 1);
    digit_valid = 1;
    digit = 4;
    enter = 1;
    exp_q.push_back(4);
    tick();
    digit_valid = 0;
    enter = 0;
    check("t5_de", digits_entered, 4);
    check("t5_noreq", cmp_req, 0);
    check("t5_nofail", pass_fail, 0);
    enter_key();
    check("t5_req", cmp_req, 1);
    respond(0);
    check("t5_fail", pass_fail, 1);
    check("t5_fails", fails, 1);
    wait_penalty();
    // two more mismatches reach the alarm
    attempt4(0, 0, 0, 0);
    respond(0);
    check("t6_fails2", fails, 2);
    check("t6_alarm_lo", alarm_req, 0);
    wait_penalty();
    attempt4(9, 9, 9, 9);
    respond(0);
    check("t6_fails3", fails, 3);
    check("t6_alarm", alarm_req, 1);
    check("t6_busy", busy, 0);
    press(3, 0);
    enter_key();
    enable = 0;
    tick();
    enable = 1;
    tick();
    check("t6_alarm_sticky", alarm_req, 1);
    check("t6_de", digits_entered, 0);
    check("t6_nfail", cnt_fail, 4);
    check("t6_nreq", cnt_req, 5);
    check("t6_q", exp_q.size(), 0);
    // asynchronous reset, including mid-comparison
    resetn = 0;
    #1;
    check("t7_alarm_clr", outs, 0);
    #2 resetn = 1;
    tick();
    attempt4(1, 2, 3, 4);
    tick();
    check("t7_wait_busy", busy, 1);
    resetn = 0;
    #1;
    check("t7_wait_reset", outs, 0);
    resetn = 1;
    cmp_done = 1;
    cmp_match = 1;
    tick();
    cmp_done = 0;
    cmp_match = 0;
    check("t7_no_ok", pass_ok, 0);
    tick();
    check("t7_outs", outs, 0);
    check("t7_q", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/passcode_entry_ctrl.md
Name: passcode_entry_ctrl

Overview:
Sequences the user-attempt keycode datapath: accepts decoded keypad digit strobes, writes exactly 4 digits into the attempt register, then hands the attempt to the validator and waits for its verdict. It counts failed attempts, enforces a post-failure penalty delay and an inactivity timeout, and raises a sticky alarm request after MAX_FAILS consecutive failures. It sits between the keyboard digit converter and the attempt load_module/validation pair, under the main alarm FSM.

Parameters:
NUM_DIGITS, 4, digits per code; attempt register is 4*NUM_DIGITS bits
MAX_FAILS, 3, consecutive failures before alarm_req
PENALTY_CYCLES, 50000000, idle cycles after a failure (1 s at CLOCK_50)
TIMEOUT_CYCLES, 500000000, inactivity cycles before a partial entry is discarded (10 s)
CNT_W, 29, width of the shared cycle counter; must hold max(PENALTY_CYCLES, TIMEOUT_CYCLES)

Ports:
clock  in  1  system clock (CLOCK_50)
resetn  in  1  asynchronous active-low reset
enable  in  1  entry permitted; 0 forces IDLE on the next edge
digit_valid  in  1  one-cycle strobe, a digit key was pressed
digit  in  4  BCD digit value, sampled with digit_valid
enter  in  1  one-cycle strobe, enter key
cmp_done  in  1  validator result strobe
cmp_match  in  1  validator verdict, valid when cmp_done=1
attempt_clr  out  1  one-cycle pulse, clear the attempt register
attempt_we  out  1  one-cycle pulse, shift digit_out into the attempt register
digit_out  out  4  registered copy of digit, valid with attempt_we
cmp_req  out  1  one-cycle pulse, start a comparison
pass_ok  out  1  one-cycle pulse, correct code accepted
pass_fail  out  1  one-cycle pulse, wrong code or premature enter
alarm_req  out  1  sticky; set after MAX_FAILS failures
digits_entered  out  3  digits accepted in the current attempt (0..NUM_DIGITS)
fails  out  2  consecutive failures so far
busy  out  1  1 in CMP, WAIT, PENALTY

Behaviour:
- Reset (async, resetn=0): state IDLE; every output 0; counters 0; alarm_req 0. alarm_req clears only on reset.
- All outputs are registered. Each pulse output lasts exactly one cycle.
- States: IDLE, ENTRY, CMP, WAIT, PENALTY, ALARM.
- IDLE: when enable=1 and digit_valid=1, go to ENTRY with attempt_clr=1 and attempt_we=1 in the same cycle (clear takes priority in the datapath, then load), and set digits_entered=1.
- ENTRY, digit_valid=1 with digits_entered<NUM_DIGITS: attempt_we=1, digit_out=digit, digits_entered+1. Digits beyond NUM_DIGITS are ignored; no write occurs.
- ENTRY, enter=1 with digits_entered==NUM_DIGITS: go to CMP.
- ENTRY, enter=1 with fewer digits: treated as a failure (same path as a WAIT mismatch).
- If digit_valid and enter arrive in the same cycle, the digit is processed first and enter is dropped.
- Timeout: the cycle counter resets on every accepted digit. When it reaches TIMEOUT_CYCLES-1 in ENTRY: attempt_clr=1, digits_entered=0, go to IDLE. A timeout does not count as a failure.
- CMP: cmp_req=1 for one cycle, then go to WAIT. Inputs are ignored.
- WAIT: inputs are ignored until cmp_done. No timeout applies; the validator must respond.
  - cmp_match=1: pass_ok=1, fails=0, attempt_clr=1, go to IDLE.
  - cmp_match=0: pass_fail=1, fails+1 (saturating at MAX_FAILS), attempt_clr=1, digits_entered=0. If the new fails==MAX_FAILS, go to ALARM; otherwise go to PENALTY and load the counter.
- PENALTY: all inputs are ignored for PENALTY_CYCLES cycles, then go to IDLE. A keypress arriving on the exit cycle is dropped.
- ALARM: alarm_req=1 and all inputs are ignored. The block leaves ALARM only on resetn.
- enable=0 in ENTRY or PENALTY: attempt_clr=1, go to IDLE. fails is retained.
- enable=0 in CMP or WAIT: the transaction completes first; enable is honoured on the return to IDLE.
- resetn asserted mid-entry: everything clears immediately, with no pulse generated.

Decomposition:
- Shared package (alarm_pkg): state encoding localparams, NUM_DIGITS, DIGIT_W=4, and the CLOCK_50 timing constants (cycles per second).
- Sub-module: cycle_timer, a loadable down-counter with a done flag, shared by the penalty and timeout functions. A single instance is used because the penalty and timeout periods never overlap.

Test Plan:
- Digits 2,2,1,1 then enter, with cmp_done+match 3 cycles after cmp_req: four attempt_we pulses carrying 2,2,1,1; one cmp_req; pass_ok on the cmp_done cycle; fails=0; state IDLE.
- Digits 1,2,3 then enter: pass_fail one cycle later, fails=1, no cmp_req, busy=1 for PENALTY_CYCLES (bench uses 8), then IDLE.
- Three full-length mismatches: fails steps 1,2,3; alarm_req rises on the third result and stays high across further digit, enter and enable activity until resetn.
- Digits 5,6, then idle for TIMEOUT_CYCLES (bench uses 16): attempt_clr pulse, digits_entered=0, fails unchanged.
- Five digits 1..5 then enter: only 1,2,3,4 are written, and cmp_req is issued.
- Same-cycle digit_valid+enter on the fourth digit: the digit is written and enter is ignored. A second enter then triggers cmp_req.
- resetn pulsed low while in WAIT: all outputs 0 immediately, and a later cmp_done is ignored.
